imem_loader: RTL and testbench

Boot-time writer for the instruction memory that the single-cycle CPU reads. It receives a byte stream carrying a header, a program image and a checksum, assembles big-endian 32-bit words and writes them into consecutive instruction-memory word addresses. It holds the CPU in reset until the image has loaded and its checksum verifies.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 39 +++
 rtl/imem_loader_word_assembler.sv | 48 ++++
 rtl/imem_loader.sv | 104 ++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Imported by the loader top and its word assembler.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);
  localparam int LEN_W          = HDR_BYTES * 8;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port bundles.
// master drives the transfer, slave receives it.
interface byte_stream_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

interface imem_wr_if #(
  parameter int ADDR_W = 10
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    input imem_we,
    input imem_addr,
    input imem_wdata
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Shifts stream bytes MSB-first into a 32-bit word.
// full_o pulses for the cycle after the last byte of a word lands.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o,
  output logic        full_o
);

  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;

  assign last_o = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    full_d = 1'b0;
    if (shift_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 1'b1;
      full_d = last_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      word_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign word_o = word_q;
  assign full_o = full_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses header/image/checksum from a byte stream,
// writes words to instruction memory and releases the CPU on success.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_WORD = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  byte_stream_if.slave  bs,
  imem_wr_if.master     mem,
  output logic          cpu_reset,
  output logic          load_done,
  output logic          load_err,
  output logic [15:0]   words_loaded
);

  localparam logic [31:0]       MAX_N = 32'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_WORD);

  state_e            state_q, state_d;
  logic              rdy_en_q;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [CSUM_W-1:0] acc_q, acc_d;
  logic [15:0]       words_q;
  logic              accept, shift;
  logic              last, full;
  logic [31:0]       word;
  logic [31:0]       n_full;

  word_assembler u_asm (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clr_i   (state_q == HDR_HI),
    .shift_i (shift),
    .byte_i  (bs.byte_data),
    .word_o  (word),
    .last_o  (last),
    .full_o  (full)
  );

  // Ready is held low one cycle after reset so the source sees a clean start.
  assign bs.byte_ready = rdy_en_q &&
    (state_q inside {HDR_HI, HDR_LO, DATA, CSUM});
  assign accept = bs.byte_valid && bs.byte_ready;
  assign n_full = {16'd0, n_q[15:8], bs.byte_data};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    acc_d   = acc_q;
    shift   = 1'b0;
    if (accept) acc_d = acc_q + bs.byte_data;
    unique case (state_q)
      HDR_HI: if (accept) begin
        n_d[15:8] = bs.byte_data;
        state_d   = HDR_LO;
      end
      HDR_LO: if (accept) begin
        n_d[7:0] = bs.byte_data;
        if (n_full > MAX_N)       state_d = ERR;
        else if (n_full == 32'd0) state_d = CSUM;
        else                      state_d = DATA;
      end
      DATA: if (accept) begin
        shift = 1'b1;
        if (last && (words_q + 16'd1) == n_q) state_d = CSUM;
      end
      CSUM: if (accept) begin
        state_d = (acc_d == '0) ? DONE : ERR;
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= HDR_HI;
      rdy_en_q <= 1'b0;
      n_q      <= '0;
      acc_q    <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      n_q      <= n_d;
      acc_q    <= acc_d;
      if (full) words_q <= words_q + 16'd1;
    end
  end

  assign mem.imem_we    = full;
  assign mem.imem_addr  = BASE + ADDR_W'(words_q);
  assign mem.imem_wdata = word;

  assign cpu_reset    = (state_q != DONE);
  assign load_done    = (state_q == DONE);
  assign load_err     = (state_q == ERR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, empty, bad checksum,
// oversize header, gapped stream and mid-load reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_reset, load_done, load_err;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [9:0]  wr_addr [8];
  logic [31:0] wr_data [8];

  byte_stream_if bs ();
  imem_wr_if #(.ADDR_W(10)) mem ();

  imem_loader #(.ADDR_W(10), .BASE_WORD(0)) dut (
    .Clk          (clk),
    .Reset        (rst),
    .bs           (bs.slave),
    .mem          (mem.master),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem.imem_we === 1'b1) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = mem.imem_addr;
        wr_data[wr_cnt] = mem.imem_wdata;
      end
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'h00;
    @(negedge clk);
    chk("rst_ready", bs.byte_ready, 0);
    chk("rst_we", mem.imem_we, 0);
    chk("rst_addr", mem.imem_addr, 0);
    chk("rst_wdata", mem.imem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_words", words_loaded, 0);
    rst = 1'b0;
    wr_cnt = 0;
    @(negedge clk);
    chk("ready_after_rst", bs.byte_ready, 1);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    @(negedge clk);
    bs.byte_valid = 1'b1;
    bs.byte_data  = b;
    t = 0;
    while (bs.byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", bs.byte_ready, 1);
    @(posedge clk);
    if (gap > 0) begin
      @(negedge clk);
      bs.byte_valid = 1'b0;
      bs.byte_data  = 8'hFF;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'h00;
  endtask

  task automatic run_stream(input logic [7:0] last, input int gap);
    logic [7:0] s [11];
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
          8'h20, 8'h09, 8'h00, 8'h0A, 8'h00};
    s[10] = last;
    for (int i = 0; i < 11; i++) send(s[i], gap);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_cnt"}, wr_cnt, 2);
    chk({tag, "_addr0"}, wr_addr[0], 0);
    chk({tag, "_data0"}, wr_data[0], 32'h2008_0005);
    chk({tag, "_addr1"}, wr_addr[1], 1);
    chk({tag, "_data1"}, wr_data[1], 32'h2009_000A);
  endtask

  initial begin
    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'h00;

    // normal load, back-to-back
    do_reset();
    run_stream(8'h9E, 0);
    idle();
    chk("norm_done", load_done, 1);
    chk("norm_cpu_reset", cpu_reset, 0);
    chk("norm_err", load_err, 0);
    chk("norm_words", words_loaded, 2);
    chk("norm_ready", bs.byte_ready, 0);
    repeat (2) @(negedge clk);
    check_writes("norm");

    // zero-length image
    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    idle();
    chk("zero_done", load_done, 1);
    chk("zero_cpu_reset", cpu_reset, 0);
    repeat (2) @(negedge clk);
    chk("zero_wr_cnt", wr_cnt, 0);
    chk("zero_words", words_loaded, 0);

    // bad checksum
    do_reset();
    run_stream(8'h9F, 0);
    idle();
    chk("bad_err", load_err, 1);
    chk("bad_done", load_done, 0);
    chk("bad_cpu_reset", cpu_reset, 1);
    chk("bad_ready", bs.byte_ready, 0);
    repeat (2) @(negedge clk);
    check_writes("bad");
    bs.byte_valid = 1'b1;
    bs.byte_data  = 8'hAA;
    repeat (6) @(negedge clk);
    bs.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bad_no_more_wr", wr_cnt, 2);
    chk("bad_words_held", words_loaded, 2);

    // N = 1024 is the largest legal count
    do_reset();
    send(8'h04, 0);
    send(8'h00, 0);
    idle();
    chk("max_err", load_err, 0);
    chk("max_ready", bs.byte_ready, 1);

    // N = 1025 overflows a 1024-word memory
    do_reset();
    send(8'h04, 0);
    send(8'h01, 0);
    idle();
    chk("over_err", load_err, 1);
    chk("over_ready", bs.byte_ready, 0);
    chk("over_cpu_reset", cpu_reset, 1);
    repeat (2) @(negedge clk);
    chk("over_wr_cnt", wr_cnt, 0);

    // gaps of 3 idle cycles between bytes
    do_reset();
    run_stream(8'h9E, 3);
    repeat (2) @(negedge clk);
    chk("gap_done", load_done, 1);
    chk("gap_cpu_reset", cpu_reset, 0);
    chk("gap_words", words_loaded, 2);
    chk("gap_ready", bs.byte_ready, 0);
    check_writes("gap");

    // reset after 6 bytes, then full reload
    do_reset();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h20, 0);
    send(8'h08, 0);
    send(8'h00, 0);
    send(8'h05, 0);
    idle();
    do_reset();
    run_stream(8'h9E, 0);
    idle();
    chk("mid_done", load_done, 1);
    chk("mid_cpu_reset", cpu_reset, 0);
    chk("mid_words", words_loaded, 2);
    repeat (2) @(negedge clk);
    check_writes("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
